// File: rtl/bitrev_pkg.sv
// Shared definitions for the bit-reverse frame reorderer.
package bitrev_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_LOG2_N     = 4;
  localparam int N                  = 1 << DEFAULT_LOG2_N;

  // Life cycle of one frame bank, derived from the full flag and the pointers.
  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL,
    DRAINING
  } bank_state_e;

  // Reverses the low 'width' bits of idx: bit k moves to bit width-1-k.
  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int width);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < width; k++) begin
      r[width-1-k] = idx[k];
    end
    return r;
  endfunction

endpackage

// File: rtl/bitrev_index.sv
// Combinational index reversal used as the read address of the frame memory.
module bitrev_index #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] idx,
  output logic [WIDTH-1:0] rev
);

  // Pure wiring: output bit i takes input bit WIDTH-1-i.
  for (genvar i = 0; i < WIDTH; i++) begin : g_swap
    assign rev[i] = idx[WIDTH-1-i];
  end

endmodule

// File: rtl/bitrev_reorder.sv
// Ping-pong frame buffer that writes samples in natural order and reads them
// back in bit-reversed order, between two valid/ready streams.
module bitrev_reorder
  import bitrev_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int LOG2_N     = DEFAULT_LOG2_N
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  frame_done
);

  localparam int NUM = 1 << LOG2_N;
  localparam logic [LOG2_N-1:0] LAST = LOG2_N'(NUM - 1);

  logic [DATA_WIDTH-1:0] mem [2][NUM];
  logic [1:0]            full;
  logic                  wr_bank;
  logic                  rd_bank;
  logic [LOG2_N-1:0]     wr_cnt;
  logic [LOG2_N-1:0]     rd_cnt;
  logic [LOG2_N-1:0]     rd_addr;
  logic                  wr_fire;
  logic                  rd_fire;
  logic                  wr_last;
  logic                  rd_last;
  bank_state_e           bank_state [2];

  // Handshakes depend only on registered flags, never on the partner's valid/ready.
  assign din_ready  = !full[wr_bank];
  assign dout_valid = full[rd_bank];
  assign wr_fire    = din_valid && din_ready;
  assign rd_fire    = dout_valid && dout_ready;
  assign wr_last    = wr_fire && (wr_cnt == LAST);
  assign rd_last    = rd_fire && (rd_cnt == LAST);

  bitrev_index #(
    .WIDTH(LOG2_N)
  ) u_rd_index (
    .idx(rd_cnt),
    .rev(rd_addr)
  );

  // Stale memory contents are hidden whenever no frame is available.
  assign dout = dout_valid ? mem[rd_bank][rd_addr] : '0;

  // Write pointer: advance per accepted sample, hop banks after the last one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_bank <= 1'b0;
      wr_cnt  <= '0;
    end else if (wr_fire) begin
      if (wr_last) begin
        wr_cnt  <= '0;
        wr_bank <= !wr_bank;
      end else begin
        wr_cnt <= wr_cnt + 1'b1;
      end
    end
  end

  // Read pointer: advance per delivered sample, hop banks and flag frame end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_bank    <= 1'b0;
      rd_cnt     <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= rd_last;
      if (rd_fire) begin
        if (rd_last) begin
          rd_cnt  <= '0;
          rd_bank <= !rd_bank;
        end else begin
          rd_cnt <= rd_cnt + 1'b1;
        end
      end
    end
  end

  // Bank occupancy: set on the last write, cleared on the last read; both may happen together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full <= '0;
    end else begin
      if (wr_last) begin
        full[wr_bank] <= 1'b1;
      end
      if (rd_last) begin
        full[rd_bank] <= 1'b0;
      end
    end
  end

  // Sample storage has no reset; its contents are only observable through a full bank.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_bank][wr_cnt] <= din;
    end
  end

  // Per-bank life-cycle state, used by the consistency assertions below.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_state[b] = EMPTY;
      if (full[b]) begin
        bank_state[b] = ((rd_bank == 1'(b)) && (rd_cnt != '0)) ? DRAINING : FULL;
      end else if (wr_bank == 1'(b)) begin
        bank_state[b] = FILLING;
      end
    end
  end

  a_write_into_filling : assert property (@(posedge clk) disable iff (reset)
    wr_fire |-> bank_state[wr_bank] == FILLING);

  a_read_from_loaded : assert property (@(posedge clk) disable iff (reset)
    rd_fire |-> (bank_state[rd_bank] inside {FULL, DRAINING}));

  a_no_set_clear_same_bank : assert property (@(posedge clk) disable iff (reset)
    !(wr_last && rd_last && (wr_bank == rd_bank)));

  a_read_index_reversed : assert property (@(posedge clk) disable iff (reset)
    rd_addr == LOG2_N'(bitrev(32'(rd_cnt), LOG2_N)));

endmodule

// File: tb/tb_bitrev_reorder.sv
// Self-checking bench for bitrev_reorder with a queue-based frame model.
module tb_bitrev_reorder;

  localparam int L  = 3;
  localparam int NS = 1 << L;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          din_ready;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          frame_done;

  logic [DW-1:0] d1_din, d1_dout;
  logic          d1_din_valid, d1_din_ready, d1_dout_valid, d1_dout_ready, d1_frame_done;
  logic [DW-1:0] d4_din, d4_dout;
  logic          d4_din_valid, d4_din_ready, d4_dout_valid, d4_dout_ready, d4_frame_done;

  int checks   = 0;
  int failures = 0;

  int exp_q[$];
  int frame_buf[$];
  int pops;
  bit fd_pending;
  bit exp_valid;
  bit exp_ready;
  bit exp_fd;
  int exp_dout;

  always #5 clk = ~clk;

  bitrev_reorder #(.DATA_WIDTH(DW), .LOG2_N(L)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .frame_done(frame_done)
  );

  bitrev_reorder #(.DATA_WIDTH(DW), .LOG2_N(1)) dut1 (
    .clk(clk), .reset(reset), .din(d1_din), .din_valid(d1_din_valid), .din_ready(d1_din_ready),
    .dout(d1_dout), .dout_valid(d1_dout_valid), .dout_ready(d1_dout_ready),
    .frame_done(d1_frame_done)
  );

  bitrev_reorder #(.DATA_WIDTH(DW), .LOG2_N(4)) dut4 (
    .clk(clk), .reset(reset), .din(d4_din), .din_valid(d4_din_valid), .din_ready(d4_din_ready),
    .dout(d4_dout), .dout_valid(d4_dout_valid), .dout_ready(d4_dout_ready),
    .frame_done(d4_frame_done)
  );

  // Arithmetic bit reversal of the low 'bits' bits of i.
  function automatic int rev(input int i, input int bits);
    int r;
    r = 0;
    for (int k = 0; k < bits; k++) begin
      r = (r << 1) | ((i >> k) & 1);
    end
    return r;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    frame_buf.delete();
    pops = 0;
    fd_pending = 1'b0;
  endtask

  // Expected outputs this cycle: a bank is held from its last write until its last read.
  task automatic model_expect();
    exp_valid = exp_q.size() > 0;
    exp_dout  = exp_valid ? exp_q[0] : 0;
    exp_ready = ((exp_q.size() + NS - 1) / NS) < 2;
    exp_fd    = fd_pending;
  endtask

  // Apply this cycle's transfers to the model.
  task automatic model_update();
    fd_pending = 1'b0;
    if (exp_valid && dout_ready) begin
      void'(exp_q.pop_front());
      pops++;
      if (pops % NS == 0) fd_pending = 1'b1;
    end
    if (din_valid && exp_ready) begin
      frame_buf.push_back(int'(din));
      if (frame_buf.size() == NS) begin
        for (int i = 0; i < NS; i++) exp_q.push_back(frame_buf[rev(i, L)]);
        frame_buf.delete();
      end
    end
  endtask

  task automatic applyStimulus(input bit v, input logic [DW-1:0] d, input bit r);
    din_valid  = v;
    din        = d;
    dout_ready = r;
    @(negedge clk);
    model_expect();
  endtask

  task automatic advance();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    din_valid = 0; din = '0; dout_ready = 0;
    d1_din_valid = 0; d1_din = '0; d1_dout_ready = 0;
    d4_din_valid = 0; d4_din = '0; d4_dout_ready = 0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (din_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_din_ready: got %b expected 1", din_ready); end
    checks++; if (dout_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_dout_valid: got %b expected 0", dout_valid); end
    checks++; if (dout !== '0) begin failures++; $display("[TB] FAIL reset_dout: got %0h expected 0", dout); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_frame_done: got %b expected 0", frame_done); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_frame();
    int order[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int outs[8];
    int sent = 0, got = 0, acc7 = -1, first_v = -1, fd = 0;
    for (int c = 0; c < 40 && (got < 8 || c < 20); c++) begin
      applyStimulus(sent < 8, DW'(sent), 1'b1);
      checks++;
      if (dout_valid !== exp_valid || din_ready !== exp_ready) begin
        failures++;
        $display("[TB] FAIL single_handshake cycle %0d: got v=%b r=%b expected v=%b r=%b", c, dout_valid, din_ready, exp_valid, exp_ready);
      end
      if (dout_valid === 1'b1 && got < 8) begin
        if (first_v < 0) first_v = c;
        outs[got] = int'(dout);
        got++;
      end
      if (frame_done === 1'b1) fd++;
      if (din_valid && din_ready === 1'b1) begin
        if (sent == 7) acc7 = c;
        sent++;
      end
      advance();
    end
    checks++; if (got != 8) begin failures++; $display("[TB] FAIL single_count: got %0d expected 8", got); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i < got && outs[i] != order[i]) begin
        failures++;
        $display("[TB] FAIL single_order[%0d]: got %0d expected %0d", i, outs[i], order[i]);
      end
    end
    checks++; if (first_v != acc7 + 1) begin failures++; $display("[TB] FAIL single_latency: got cycle %0d expected %0d", first_v, acc7 + 1); end
    checks++; if (fd != 1) begin failures++; $display("[TB] FAIL single_frame_done: got %0d pulses expected 1", fd); end
  endtask

  task automatic test_back_to_back();
    int second[8] = '{8, 12, 10, 14, 9, 13, 11, 15};
    int outs[24];
    int sent = 0, got = 0, gaps = 0, fd = 0;
    for (int c = 0; c < 100 && got < 24; c++) begin
      applyStimulus(sent < 24, DW'(sent), 1'b1);
      checks++;
      if (dout_valid !== exp_valid || (exp_valid && dout !== DW'(exp_dout))) begin
        failures++;
        $display("[TB] FAIL b2b_data cycle %0d: got v=%b d=%0d expected v=%b d=%0d", c, dout_valid, dout, exp_valid, exp_dout);
      end
      if (dout_valid === 1'b1) begin
        outs[got] = int'(dout);
        got++;
      end else if (got > 0) begin
        gaps++;
      end
      if (frame_done === 1'b1) fd++;
      if (din_valid && din_ready === 1'b1) sent++;
      advance();
    end
    checks++; if (got != 24) begin failures++; $display("[TB] FAIL b2b_count: got %0d expected 24", got); end
    checks++; if (gaps != 0) begin failures++; $display("[TB] FAIL b2b_gaps: got %0d expected 0", gaps); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (outs[8 + i] != second[i]) begin
        failures++;
        $display("[TB] FAIL b2b_second[%0d]: got %0d expected %0d", i, outs[8 + i], second[i]);
      end
    end
    repeat (2) begin
      applyStimulus(1'b0, '0, 1'b1);
      if (frame_done === 1'b1) fd++;
      advance();
    end
    checks++; if (fd != 3) begin failures++; $display("[TB] FAIL b2b_frame_done: got %0d expected 3", fd); end
  endtask

  task automatic test_backpressure();
    int accepted = 0, reads = 0, r8 = -1, rr = -1;
    for (int c = 0; c < 24; c++) begin
      applyStimulus(1'b1, DW'(accepted), 1'b0);
      checks++;
      if (din_ready !== exp_ready || dout_valid !== exp_valid) begin
        failures++;
        $display("[TB] FAIL bp_fill cycle %0d: got r=%b v=%b expected r=%b v=%b", c, din_ready, dout_valid, exp_ready, exp_valid);
      end
      if (dout_valid === 1'b1) begin
        checks++;
        if (dout !== 8'd0) begin failures++; $display("[TB] FAIL bp_hold cycle %0d: got %0d expected 0", c, dout); end
      end
      if (din_ready === 1'b1) accepted++;
      advance();
    end
    checks++; if (accepted != 16) begin failures++; $display("[TB] FAIL bp_accepted: got %0d expected 16", accepted); end
    checks++; if (din_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_stalled: got %b expected 0", din_ready); end
    for (int c = 0; c < 40 && reads < 16; c++) begin
      applyStimulus(1'b0, '0, 1'b1);
      checks++;
      if (din_ready !== exp_ready || (exp_valid && dout !== DW'(exp_dout))) begin
        failures++;
        $display("[TB] FAIL bp_drain cycle %0d: got r=%b d=%0d expected r=%b d=%0d", c, din_ready, dout, exp_ready, exp_dout);
      end
      if (din_ready === 1'b1 && rr < 0) rr = c;
      if (dout_valid === 1'b1) begin
        reads++;
        if (reads == 8) r8 = c;
      end
      advance();
    end
    checks++; if (rr != r8 + 1) begin failures++; $display("[TB] FAIL bp_ready_return: got cycle %0d expected %0d", rr, r8 + 1); end
    checks++; if (reads != 16) begin failures++; $display("[TB] FAIL bp_reads: got %0d expected 16", reads); end
    applyStimulus(1'b0, '0, 1'b1);
    advance();
  endtask

  task automatic test_random();
    int sent = 0, got = 0, fd = 0;
    for (int c = 0; c < 6000 && (got < 160 || c < 3); c++) begin
      applyStimulus((sent < 160) && ($urandom_range(1) == 1), DW'($urandom), $urandom_range(1) == 1);
      checks++;
      if (dout_valid !== exp_valid || din_ready !== exp_ready || frame_done !== exp_fd) begin
        failures++;
        $display("[TB] FAIL rand_ctrl cycle %0d: got v=%b r=%b fd=%b expected v=%b r=%b fd=%b", c, dout_valid, din_ready, frame_done, exp_valid, exp_ready, exp_fd);
      end
      checks++;
      if (dout !== DW'(exp_dout)) begin
        failures++;
        $display("[TB] FAIL rand_data cycle %0d: got %0h expected %0h", c, dout, exp_dout);
      end
      if (frame_done === 1'b1) fd++;
      if (dout_valid === 1'b1 && dout_ready) got++;
      if (din_valid && din_ready === 1'b1) sent++;
      advance();
    end
    repeat (2) begin
      applyStimulus(1'b0, '0, 1'b1);
      if (frame_done === 1'b1) fd++;
      advance();
    end
    checks++; if (got != 160) begin failures++; $display("[TB] FAIL rand_count: got %0d expected 160", got); end
    checks++; if (exp_q.size() != 0 || dout_valid !== 1'b0) begin failures++; $display("[TB] FAIL rand_leftover: got v=%b model %0d expected empty", dout_valid, exp_q.size()); end
    checks++; if (fd != 20) begin failures++; $display("[TB] FAIL rand_frame_done: got %0d expected 20", fd); end
  endtask

  task automatic test_reset_mid();
    int order[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int sent = 0, sent2 = 0, got = 0;
    for (int c = 0; c < 30 && sent < 8; c++) begin
      applyStimulus(1'b1, DW'(sent), 1'b0);
      if (din_ready === 1'b1) sent++;
      advance();
    end
    for (int c = 0; c < 30 && sent2 < 5; c++) begin
      applyStimulus(1'b1, DW'(8 + sent2), 1'b1);
      if (din_ready === 1'b1) sent2++;
      advance();
    end
    din_valid = 0;
    dout_ready = 1;
    checks++; if (dout_valid !== 1'b1) begin failures++; $display("[TB] FAIL mid_draining: got %b expected 1", dout_valid); end
    reset = 1'b1;
    #1;
    checks++; if (dout_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_valid: got %b expected 0", dout_valid); end
    checks++; if (din_ready !== 1'b1) begin failures++; $display("[TB] FAIL mid_reset_ready: got %b expected 1", din_ready); end
    checks++; if (dout !== '0) begin failures++; $display("[TB] FAIL mid_reset_dout: got %0h expected 0", dout); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    sent = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      applyStimulus(sent < 8, DW'(sent), 1'b1);
      if (dout_valid === 1'b1) begin
        checks++;
        if (int'(dout) != order[got]) begin
          failures++;
          $display("[TB] FAIL mid_order[%0d]: got %0d expected %0d", got, dout, order[got]);
        end
        got++;
      end
      if (din_valid && din_ready === 1'b1) sent++;
      advance();
    end
    checks++; if (got != 8) begin failures++; $display("[TB] FAIL mid_count: got %0d expected 8", got); end
    applyStimulus(1'b0, '0, 1'b1);
    advance();
  endtask

  task automatic test_log2n_1();
    logic [DW-1:0] vals[2];
    int sent = 0, got = 0, fd = 0;
    vals[0] = DW'($urandom);
    vals[1] = DW'($urandom);
    for (int c = 0; c < 20 && (got < 2 || c < 8); c++) begin
      d1_din_valid = sent < 2;
      d1_din = vals[sent % 2];
      d1_dout_ready = 1'b1;
      @(negedge clk);
      if (d1_dout_valid === 1'b1 && got < 2) begin
        checks++;
        if (d1_dout !== vals[got]) begin
          failures++;
          $display("[TB] FAIL n2_order[%0d]: got %0h expected %0h", got, d1_dout, vals[got]);
        end
        got++;
      end
      if (d1_frame_done === 1'b1) fd++;
      if (d1_din_valid && d1_din_ready === 1'b1) sent++;
      @(posedge clk);
      #1;
    end
    d1_din_valid = 0;
    checks++; if (got != 2) begin failures++; $display("[TB] FAIL n2_count: got %0d expected 2", got); end
    checks++; if (fd != 1) begin failures++; $display("[TB] FAIL n2_frame_done: got %0d expected 1", fd); end
  endtask

  task automatic test_log2n_4();
    int sent = 0, got = 0;
    for (int c = 0; c < 80 && got < 16; c++) begin
      d4_din_valid = sent < 16;
      d4_din = DW'(sent);
      d4_dout_ready = 1'b1;
      @(negedge clk);
      if (d4_dout_valid === 1'b1) begin
        checks++;
        if (int'(d4_dout) != rev(got, 4)) begin
          failures++;
          $display("[TB] FAIL n16_order[%0d]: got %0d expected %0d", got, d4_dout, rev(got, 4));
        end
        got++;
      end
      if (d4_din_valid && d4_din_ready === 1'b1) sent++;
      @(posedge clk);
      #1;
    end
    d4_din_valid = 0;
    checks++; if (got != 16) begin failures++; $display("[TB] FAIL n16_count: got %0d expected 16", got); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_log2n_1();
    test_log2n_4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
